bt_update_scheduler: RTL

BT_UPDATE_SCHEDULER -- requirements
Module: bt_update_scheduler

---
 rtl/bt_update_scheduler_pkg.sv | 32 +++
 rtl/bt_update_queue.sv | 88 ++++++++
 rtl/bt_update_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bt_update_scheduler_pkg.sv
// rtl/bt_update_scheduler_pkg.sv - shared types and constants for the BTB update scheduler
//
// Purpose: BTB update record, default BTB geometry, scheduler state encoding
//          and a saturating add used by the optional drop statistics.
// Ports:   none (package).
// Config:  BT_UPDATE_DROP_STATS_EN selects use of sat_add16 in the top.

package bt_update_scheduler_pkg;

  localparam int BTB_ENTRIES = 64;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int ADDR_W      = 32;

  // One branch-target update: branch address and resolved target.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
  } BTUpdate;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/bt_update_queue.sv
// rtl/bt_update_queue.sv - multi-push, single-pop FIFO of BTB updates
//
// Purpose: accepts up to NUM_IN valid updates per cycle in ascending port
//          order, limited to the free slots at the start of the cycle; extra
//          updates are silently dropped. One entry pops per cycle.
// Ports:   clk, rst (sync, active-low), flush (empty the queue),
//          push_en (gate all pushes), pop (remove head if non-empty),
//          push_data[NUM_IN] (valid bit per entry), head (oldest entry),
//          count (registered occupancy).

module bt_update_queue import bt_update_scheduler_pkg::*; #(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_en,
  input  logic             pop,
  input  BTUpdate          push_data [NUM_IN],
  output BTUpdate          head,
  output logic [CNT_W-1:0] count
);

  BTUpdate          mem_q [DEPTH];
  BTUpdate          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             do_pop;
  logic [PTR_W-1:0] slot;
  int               n_free;
  int               n_push;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot     = wr_ptr_q;
    do_pop   = pop && (count_q != '0);
    // Free space is judged on the start-of-cycle occupancy, so a same-cycle
    // pop does not open room for an extra push.
    n_free   = DEPTH - int'(count_q);
    n_push   = 0;

    if (push_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push_data[i].valid && (n_push < n_free)) begin
          slot        = wr_ptr_q + PTR_W'(n_push);
          mem_d[slot] = push_data[i];
          n_push      = n_push + 1;
        end
      end
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(n_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bt_update_scheduler.sv
// rtl/bt_update_scheduler.sv - funnels branch-unit updates into the BTB write port and runs BTB clears
//
// Purpose: queues target updates from NUM_IN branch units and presents them
//          one per cycle to the BTB write port; on reset or IN_clearICache it
//          flushes the queue and walks every BTB entry with a clear write.
// Ports:   clk, rst (sync, active-low), IN_clearICache (start full clear),
//          IN_btUpdates[NUM_IN] (incoming updates), IN_btbReady (BTB accepts
//          OUT_btUpdate), OUT_btUpdate (queue head), OUT_clrValid/OUT_clrIdx
//          (entry clear write), OUT_stall (fetch stall request),
//          OUT_dropCnt (only with BT_UPDATE_DROP_STATS_EN: saturating count
//          of updates dropped for lack of queue space).
// Config:  BT_UPDATE_DROP_STATS_EN adds the drop counter and its port.

module bt_update_scheduler import bt_update_scheduler_pkg::*; #(
  parameter int NUM_IN      = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int BTB_ENTRIES = bt_update_scheduler_pkg::BTB_ENTRIES,
  localparam int IDX_W      = $clog2(BTB_ENTRIES),
  localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_clearICache,
  input  BTUpdate          IN_btUpdates [NUM_IN],
  input  logic             IN_btbReady,
  output BTUpdate          OUT_btUpdate,
  output logic             OUT_clrValid,
  output logic [IDX_W-1:0] OUT_clrIdx,
  output logic             OUT_stall
`ifdef BT_UPDATE_DROP_STATS_EN
  ,
  output logic [15:0]      OUT_dropCnt
`endif
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic             q_flush;
  logic             q_push_en;
  logic             q_pop;
  BTUpdate          q_head;
  logic [CNT_W-1:0] q_count;

  bt_update_queue #(
    .NUM_IN (NUM_IN),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (q_flush),
    .push_en   (q_push_en),
    .pop       (q_pop),
    .push_data (IN_btUpdates),
    .head      (q_head),
    .count     (q_count)
  );

  always_comb begin
    state_d            = state_q;
    clr_idx_d          = clr_idx_q;
    q_flush            = 1'b0;
    q_push_en          = 1'b0;
    q_pop              = 1'b0;
    OUT_btUpdate       = q_head;
    OUT_btUpdate.valid = 1'b0;
    OUT_clrValid       = 1'b0;
    OUT_clrIdx         = clr_idx_q;

    case (state_q)
      ST_IDLE: begin
        OUT_btUpdate.valid = (q_count != '0);
        // The head handed to the BTB this cycle is consumed even if a clear
        // starts in the same cycle.
        q_pop = (q_count != '0) && IN_btbReady;
        if (IN_clearICache) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
          q_flush   = 1'b1;
        end else begin
          q_push_en = 1'b1;
        end
      end
      ST_CLEAR: begin
        OUT_clrValid = 1'b1;
        // Holding the queue in flush discards anything arriving mid-clear.
        q_flush      = 1'b1;
        if (IN_clearICache) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_W'(BTB_ENTRIES - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Stall looks only at registered state so fetch sees a stable request;
  // the threshold leaves room for one full cycle of pushes.
  assign OUT_stall = (state_q == ST_CLEAR) || (int'(q_count) > (QUEUE_DEPTH - NUM_IN));

`ifdef BT_UPDATE_DROP_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  int          n_valid;
  int          n_room;
  int          n_drop;

  // Mirrors the queue's acceptance rule: the first n_room valid ports get in.
  always_comb begin
    n_valid = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (IN_btUpdates[i].valid) begin
        n_valid = n_valid + 1;
      end
    end
    n_room     = QUEUE_DEPTH - int'(q_count);
    n_drop     = (n_valid > n_room) ? (n_valid - n_room) : 0;
    drop_cnt_d = drop_cnt_q;
    if (IN_clearICache) begin
      drop_cnt_d = '0;
    end else if (q_push_en) begin
      drop_cnt_d = sat_add16(drop_cnt_q, 16'(n_drop));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign OUT_dropCnt = drop_cnt_q;
`endif

endmodule
